// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, opcodes and the opcode classifier for the fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    CLS_I   = 2'd0,
    CLS_R   = 2'd1,
    CLS_S   = 2'd2,
    CLS_ILL = 2'd3
  } instr_class_t;

  localparam logic [6:0] OPC_I = 7'h13;
  localparam logic [6:0] OPC_R = 7'h33;
  localparam logic [6:0] OPC_S = 7'h03;

  typedef struct packed {
    logic [31:0]  instr;
    logic [31:0]  pc;
    instr_class_t cls;
  } fetch_entry_t;

  function automatic instr_class_t classify(input logic [6:0] opc);
    case (opc)
      OPC_I:   return CLS_I;
      OPC_R:   return CLS_R;
      OPC_S:   return CLS_S;
      default: return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular-buffer FIFO with read/write pointers and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_wr    = wr_en && (count_q != CW'(DEPTH));
    do_rd    = rd_en && (count_q != '0);
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_rd) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - credit-based sequential fetch with PC/class tagging into a decode FIFO
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int XLEN   = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic                       next_op,
  input  logic [XLEN-1:0]            instr_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [1:0]                 out_class,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PCW = ADDR_W + 2;

  logic           inflight_q, inflight_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [CW-1:0]  fifo_count;
  logic           push, pop, credit_ok;
  fetch_entry_t   wr_entry, head;

  // Requests in flight already own a slot, so the FIFO can never overflow.
  assign credit_ok = ({1'b0, fifo_count} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
  assign next_op   = fetch_en & ~reset & credit_ok;
  assign push      = inflight_q & ~reset;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    inflight_d     = next_op;
    pc_d           = push ? pc_q + PCW'(4) : pc_q;
    wr_entry.instr = 32'(instr_in);
    wr_entry.pc    = 32'(pc_q);
    wr_entry.cls   = classify(instr_in[6:0]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      inflight_q <= inflight_d;
      pc_q       <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign out_instr = out_valid ? XLEN'(head.instr) : '0;
  assign out_pc    = out_valid ? XLEN'(head.pc) : '0;
  assign out_class = out_valid ? head.cls : 2'd0;
  assign count     = fifo_count;

  overflow_chk: assert property (@(posedge clock) disable iff (reset)
    !(push && fifo_count == CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - randomized self-checking bench with a sequential memory and stream model
module tb_instr_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;
  localparam int XLEN   = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr_in = '0;
  logic        next_op, out_valid;
  logic [31:0] out_instr, out_pc;
  logic [1:0]  out_class;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem_words [64];
  int   mem_ptr = 0;
  logic req_s = 1'b0;
  logic rst_s = 1'b1;
  int   k = 0;
  int   nreq = 0;

  always #5 clock = ~clock;

  instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .next_op(next_op),
    .instr_in(instr_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_class(out_class), .count(count)
  );

  function automatic logic [1:0] ref_class(input logic [31:0] w);
    if (w[6:0] == 7'h13) return 2'd0;
    if (w[6:0] == 7'h33) return 2'd1;
    if (w[6:0] == 7'h03) return 2'd2;
    return 2'd3;
  endfunction

  // Memory: registered sequential read; request sampled mid-cycle to avoid edge races.
  always @(negedge clock) begin
    req_s <= next_op;
    rst_s <= reset;
  end

  always @(posedge clock) begin
    if (req_s) instr_in <= mem_words[mem_ptr % 64];
    if (rst_s) mem_ptr <= 0;
    else if (req_s) mem_ptr <= mem_ptr + 1;
  end

  // Stream monitor: the k-th accepted entry since reset must be word k at byte PC 4k.
  always @(negedge clock) begin
    logic [31:0] e_instr, e_pc;
    logic [1:0]  e_cls;
    if (reset) begin
      k = 0;
    end else begin
      if (next_op) nreq++;
      checks++;
      if (count > 3'(DEPTH)) begin
        failures++;
        $display("FAIL occupancy: count=%0d max=%0d", count, DEPTH);
      end
      if (out_valid && out_ready) begin
        e_instr = mem_words[k % 64];
        e_pc    = 32'((k * 4) % (4 << ADDR_W));
        e_cls   = ref_class(e_instr);
        checks++;
        if ({out_instr, out_pc, out_class} !== {e_instr, e_pc, e_cls}) begin
          failures++;
          $display("FAIL stream[%0d]: got instr=%08h pc=%0d cls=%0d want instr=%08h pc=%0d cls=%0d",
                   k, out_instr, out_pc, out_class, e_instr, e_pc, e_cls);
        end
        k++;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic wait_count3(output bit ok);
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      if (count == 3'd3) begin ok = 1; break; end
      tick;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL wait_count3: timeout count=%0d want=3", count); end
  endtask

  task automatic test_reset;
    reset = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    #1;
    check("reset_next_op_dominant", 32'(next_op), 0);
    tick; tick;
    check("reset_count", 32'(count), 0);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_instr", out_instr, 0);
    check("reset_out_pc", out_pc, 0);
    check("reset_out_class", 32'(out_class), 0);
    reset = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_latency;
    int gaps;
    do_reset;
    fetch_en = 1'b1; out_ready = 1'b1;
    #1;
    check("lat_c0_next_op", 32'(next_op), 1);
    check("lat_c0_out_valid", 32'(out_valid), 0);
    tick;
    check("lat_c1_out_valid", 32'(out_valid), 0);
    tick;
    check("lat_c2_out_valid", 32'(out_valid), 1);
    check("lat_c2_instr", out_instr, 32'h00A00093);
    check("lat_c2_pc", out_pc, 0);
    check("lat_c2_class", 32'(out_class), 32'(CLS_I));
    gaps = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (!out_valid) gaps++;
    end
    check("lat_throughput_gaps", 32'(gaps), 0);
  endtask

  task automatic test_stall;
    do_reset;
    fetch_en = 1'b1; out_ready = 1'b0; nreq = 0;
    repeat (12) tick;
    check("stall_next_op_pulses", 32'(nreq), 4);
    check("stall_count", 32'(count), 4);
    check("stall_next_op", 32'(next_op), 0);
    check("stall_head_instr", out_instr, 32'h00A00093);
    check("stall_head_pc", out_pc, 0);
    for (int i = 0; i < 120; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick;
    end
    checks++;
    if (k < 20) begin failures++; $display("FAIL stall_progress: pops=%0d want>=20", k); end
  endtask

  task automatic test_simul;
    bit ok;
    do_reset;
    fetch_en = 1'b1; out_ready = 1'b0;
    tick;
    wait_count3(ok);
    check("simul_no_req_at_3", 32'(next_op), 0);
    out_ready = 1'b1;
    tick;
    check("simul_count_held", 32'(count), 3);
    check("simul_head_pc", out_pc, 4);
  endtask

  task automatic test_drop;
    int bad;
    do_reset;
    fetch_en = 1'b1; out_ready = 1'b0;
    #1;
    check("drop_c0_next_op", 32'(next_op), 1);
    tick;
    fetch_en = 1'b0;
    #1;
    check("drop_c1_next_op", 32'(next_op), 0);
    check("drop_c1_count", 32'(count), 0);
    tick;
    check("drop_c2_count", 32'(count), 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (next_op) bad++;
      tick;
    end
    check("drop_no_requests", 32'(bad), 0);
    check("drop_count_final", 32'(count), 1);
    out_ready = 1'b1;
    tick;
    check("drop_drained", 32'(count), 0);
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset;
    fetch_en = 1'b1; out_ready = 1'b0;
    tick;
    wait_count3(ok);
    reset = 1'b1;
    tick;
    check("rmid_count", 32'(count), 0);
    check("rmid_out_valid", 32'(out_valid), 0);
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin ok = 1; break; end
      tick;
    end
    check("rmid_valid_seen", 32'(ok), 1);
    check("rmid_first_pc", out_pc, 0);
    check("rmid_first_instr", out_instr, mem_words[0]);
  endtask

  task automatic test_class_wrap;
    logic [6:0] opcs [5];
    bit wrap_checked;
    opcs[0] = 7'h13; opcs[1] = 7'h33; opcs[2] = 7'h03; opcs[3] = 7'h6F;
    for (int i = 0; i < 64; i++) begin
      opcs[4] = 7'($urandom);
      mem_words[i] = {25'($urandom), opcs[$urandom_range(0, 4)]};
    end
    mem_words[0] = 32'h0000006F;
    do_reset;
    fetch_en = 1'b1; out_ready = 1'b1;
    tick; tick;
    check("ill_valid", 32'(out_valid), 1);
    check("ill_instr", out_instr, 32'h0000006F);
    check("ill_class", 32'(out_class), 32'(CLS_ILL));
    wrap_checked = 0;
    for (int i = 0; i < 400 && k < 70; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick;
      if (!wrap_checked && k == 64 && out_valid) begin
        wrap_checked = 1;
        check("wrap_pc", out_pc, 0);
      end
    end
    check("wrap_seen", 32'(wrap_checked), 1);
    checks++;
    if (k < 70) begin failures++; $display("FAIL wrap_progress: pops=%0d want>=70", k); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      case (i % 3)
        0:       mem_words[i] = 32'h00A00093;
        1:       mem_words[i] = 32'h00108133;
        default: mem_words[i] = 32'h00208203;
      endcase
    end
    test_reset;
    test_latency;
    test_stall;
    test_simul;
    test_drop;
    test_reset_mid;
    test_class_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
